// File: rtl/uart_pkg.sv
// Shared definitions for the extended UART receiver: FSM encoding, parity modes,
// FIFO entry layout and the majority-vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } rx_state_e;

    localparam logic [1:0] ParNone = 2'b00;
    localparam logic [1:0] ParEven = 2'b01;
    localparam logic [1:0] ParOdd  = 2'b10;

    localparam int unsigned ByteW    = 8;
    localparam int unsigned PerrPos  = 8;
    localparam int unsigned FerrPos  = 9;
    localparam int unsigned BreakPos = 10;
    localparam int unsigned EntryW   = 11;

    localparam logic [15:0] MinClksPerBit = 16'd4;

    function automatic logic maj3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

endpackage

// File: rtl/uart_rx_ext_if.sv
// Receive-side pop interface: show-ahead head entry with valid/ready handshake.
interface uart_rx_ext_if;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_byte;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_break;

    modport master (
        output rx_valid, rx_byte, rx_perr, rx_ferr, rx_break,
        input  rx_ready
    );

    modport slave (
        input  rx_valid, rx_byte, rx_perr, rx_ferr, rx_break,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; head data reads as zero while empty.
module uart_rx_fifo #(
    parameter int unsigned Width = 11,
    parameter int unsigned Depth = 8
) (
    input  logic                   i_Clock,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic [Width-1:0]       wdata,
    input  logic                   pop,
    output logic [Width-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(Depth));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge i_Clock) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ext.sv
// Runtime-configurable UART receiver with majority-vote sampling, per-frame
// parity/framing/break status and a show-ahead receive FIFO.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        i_Clock,
    input  logic                        rst_i,
    input  logic                        i_Rx_Serial,
    input  logic [15:0]                 CLKS_PER_BIT,
    input  logic [1:0]                  i_Data_Bits,
    input  logic [1:0]                  i_Parity,
    input  logic                        i_Stop2,
    uart_rx_ext_if.master               rx_bus,
    output logic                        o_Overrun,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);
    rx_state_e   state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [2:0]  hist_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        par_bit_q, par_bit_d;
    logic        ferr_q, ferr_d;
    logic        second_q, second_d;
    logic [15:0] cfg_cpb_q, cfg_cpb_d;
    logic [1:0]  cfg_bits_q, cfg_bits_d;
    logic [1:0]  cfg_par_q, cfg_par_d;
    logic        cfg_stop2_q, cfg_stop2_d;

    logic              sample, line, bit_done, parity_en, ferr_new, perr, brk;
    logic              push, pop, full, empty;
    logic [EntryW-1:0] push_entry, head;

    assign line      = sync2_q;
    assign sample    = maj3(hist_q);
    assign bit_done  = (cnt_q == cfg_cpb_q - 16'd1);
    assign parity_en = (cfg_par_q == ParEven) || (cfg_par_q == ParOdd);
    assign ferr_new  = ferr_q | ~sample;
    assign perr      = parity_en & ((^data_q) ^ par_bit_q ^ (cfg_par_q == ParOdd));
    assign brk       = ferr_new & (data_q == '0) & (~parity_en | ~par_bit_q);
    assign push_entry = {brk, ferr_new, perr, data_q};

    always_ff @(posedge i_Clock) begin
        if (rst_i) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            hist_q      <= 3'b111;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            par_bit_q   <= 1'b0;
            ferr_q      <= 1'b0;
            second_q    <= 1'b0;
            cfg_cpb_q   <= MinClksPerBit;
            cfg_bits_q  <= '0;
            cfg_par_q   <= ParNone;
            cfg_stop2_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= i_Rx_Serial;
            sync2_q     <= sync1_q;
            hist_q      <= {hist_q[1:0], sync2_q};
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            par_bit_q   <= par_bit_d;
            ferr_q      <= ferr_d;
            second_q    <= second_d;
            cfg_cpb_q   <= cfg_cpb_d;
            cfg_bits_q  <= cfg_bits_d;
            cfg_par_q   <= cfg_par_d;
            cfg_stop2_q <= cfg_stop2_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        data_d      = data_q;
        par_bit_d   = par_bit_q;
        ferr_d      = ferr_q;
        second_d    = second_q;
        cfg_cpb_d   = cfg_cpb_q;
        cfg_bits_d  = cfg_bits_q;
        cfg_par_d   = cfg_par_q;
        cfg_stop2_d = cfg_stop2_q;
        push        = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                idx_d     = '0;
                data_d    = '0;
                par_bit_d = 1'b0;
                ferr_d    = 1'b0;
                second_d  = 1'b0;
                if (!line) begin
                    state_d     = StStart;
                    cfg_cpb_d   = (CLKS_PER_BIT < MinClksPerBit) ? MinClksPerBit : CLKS_PER_BIT;
                    cfg_bits_d  = i_Data_Bits;
                    cfg_par_d   = i_Parity;
                    cfg_stop2_d = i_Stop2;
                end
            end
            StStart: begin
                if (cnt_q == ((cfg_cpb_q - 16'd1) >> 1)) begin
                    cnt_d   = '0;
                    state_d = sample ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (bit_done) begin
                    cnt_d         = '0;
                    data_d[idx_q] = sample;
                    if (idx_q == {1'b0, cfg_bits_q} + 3'd4) begin
                        state_d = parity_en ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StParity: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    par_bit_d = sample;
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (bit_done) begin
                    cnt_d  = '0;
                    ferr_d = ferr_new;
                    if (cfg_stop2_q && !second_q) begin
                        second_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        // A low final stop means break/framing: wait for idle before re-arming.
                        state_d = sample ? StIdle : StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWaitHigh: begin
                if (line) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pop       = rx_bus.rx_valid & rx_bus.rx_ready;
    assign o_Overrun = push & full & ~pop;

    uart_rx_fifo #(
        .Width (EntryW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .rst_i   (rst_i),
        .push    (push),
        .wdata   (push_entry),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (o_Fifo_Count)
    );

    assign rx_bus.rx_valid = ~empty;
    assign rx_bus.rx_byte  = head[ByteW-1:0];
    assign rx_bus.rx_perr  = head[PerrPos];
    assign rx_bus.rx_ferr  = head[FerrPos];
    assign rx_bus.rx_break = head[BreakPos];

endmodule
